// File: rtl/tank_sensor_emu.sv
// Water-tank emulator: integrates fill/drain commands into a saturating volume
// and drives five thermometer-coded level-sensor lines (s5 lowest, s1 highest).
// Optional build macro TANK_LEAK_EN adds a periodic leak that drains one unit
// every LEAK_PERIOD cycles while the tank is not empty.
module tank_sensor_emu #(
  parameter int unsigned TICKS_PER_STEP  = 8,
  parameter int unsigned STEPS_PER_LEVEL = 4,
  parameter int unsigned LEAK_PERIOD     = 64,
  localparam int unsigned VOL_MAX        = 5 * STEPS_PER_LEVEL,
  localparam int unsigned VW             = $clog2(VOL_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill,
  input  logic          drain,
  input  logic          clr_ovf,
  output logic          s1,
  output logic          s2,
  output logic          s3,
  output logic          s4,
  output logic          s5,
  output logic [2:0]    lvl,
  output logic [VW-1:0] vol,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic [1:0]    state
);

  localparam int unsigned PW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFill  = 2'b01,
    StDrain = 2'b10,
    StAlarm = 2'b11
  } state_e;

  // Parameter sanity checks at elaboration time.
  if (TICKS_PER_STEP < 1) begin : g_bad_ticks
    $error("TICKS_PER_STEP must be >= 1");
  end
  if (LEAK_PERIOD < 1) begin : g_bad_leak
    $error("LEAK_PERIOD must be >= 1");
  end

  state_e          cmd;
  state_e          prev_cmd_q;
  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d, presc_eff;
  logic [VW-1:0]   vol_q, vol_d;
  logic            ovf_q, ovf_d;
  logic            tick, up, dn, ovf_set;
  logic            leak_hit;
  logic [4:0]      sens_q, sens_d;
  logic [2:0]      lvl_q, lvl_d;

  // Command decode: exactly one valve open selects a direction, otherwise idle.
  always_comb begin
    cmd = StIdle;
    if (fill && !drain) begin
      cmd = StFill;
    end else if (drain && !fill) begin
      cmd = StDrain;
    end
  end

`ifdef TANK_LEAK_EN
  localparam int unsigned LW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;

  logic [LW-1:0] leak_cnt_q;
  logic          leak_tick;

  assign leak_tick = (leak_cnt_q == LW'(LEAK_PERIOD - 1));
  assign leak_hit  = leak_tick && (vol_q != '0);

  // Free-running leak period counter, independent of commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leak_cnt_q <= '0;
    end else if (leak_tick) begin
      leak_cnt_q <= '0;
    end else begin
      leak_cnt_q <= leak_cnt_q + 1'b1;
    end
  end
`else
  assign leak_hit = 1'b0;
`endif

  // Next-state: prescaler, volume integration, sticky overflow and state code.
  always_comb begin
    // A new direction (or leaving idle) restarts the step period from zero.
    presc_eff = (cmd != prev_cmd_q) ? '0 : presc_q;
    tick      = (cmd != StIdle) && (presc_eff == PW'(TICKS_PER_STEP - 1));
    presc_d   = ((cmd == StIdle) || tick) ? '0 : presc_eff + 1'b1;

    up      = tick && (cmd == StFill);
    dn      = tick && (cmd == StDrain);
    // A leak cancels a coinciding fill step, so it cannot overflow.
    ovf_set = up && !leak_hit && (vol_q == VW'(VOL_MAX));

    vol_d = vol_q;
    if (up) begin
      if (!leak_hit && (vol_q != VW'(VOL_MAX))) begin
        vol_d = vol_q + 1'b1;
      end
    end else if (dn) begin
      if (leak_hit) begin
        vol_d = (vol_q >= VW'(2)) ? vol_q - VW'(2) : '0;
      end else if (vol_q != '0) begin
        vol_d = vol_q - 1'b1;
      end
    end else if (leak_hit) begin
      vol_d = vol_q - 1'b1;
    end

    // Set wins over clear.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    state_d = ovf_d ? StAlarm : cmd;
  end

  // Main tank state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cmd_q <= StIdle;
      presc_q    <= '0;
      vol_q      <= '0;
      ovf_q      <= 1'b0;
      state_q    <= StIdle;
    end else begin
      prev_cmd_q <= cmd;
      presc_q    <= presc_d;
      vol_q      <= vol_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
    end
  end

  // Sensor thresholds on the registered volume; result is a thermometer code.
  always_comb begin
    sens_d = '0;
    lvl_d  = '0;
    for (int k = 0; k < 5; k++) begin
      sens_d[k] = (vol_q >= VW'((k + 1) * STEPS_PER_LEVEL));
      lvl_d     = lvl_d + {2'b00, sens_d[k]};
    end
  end

  // Sensor outputs lag the volume by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sens_q <= '0;
      lvl_q  <= '0;
    end else begin
      sens_q <= sens_d;
      lvl_q  <= lvl_d;
    end
  end

  assign s5    = sens_q[0];
  assign s4    = sens_q[1];
  assign s3    = sens_q[2];
  assign s2    = sens_q[3];
  assign s1    = sens_q[4];
  assign lvl   = lvl_q;
  assign vol   = vol_q;
  assign full  = (vol_q == VW'(VOL_MAX));
  assign empty = (vol_q == '0);
  assign ovf   = ovf_q;
  assign state = state_q;

endmodule
